hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core. It is the source side of the stage-register control interface: it generates the stall, flush and clear signals that the F/D/E/M/W pipeline registers consume (FlushE drives the D→E register clear).
- It also generates the forwarding selects.
- It sequences a post-reset warm-up flush and a multi-cycle data-memory wait with timeout, and counts stall cycles.

---
 rtl/hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: stall/flush/forward generation,
// post-reset warm-up flush, data-memory wait sequencing with timeout, stall counting.
module hazard_ctrl #(
    parameter int unsigned WARMUP      = 3,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic             MemAccessM,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned WARM_W = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

    typedef enum logic [1:0] {
        ST_WARM  = 2'd0,
        ST_RUN   = 2'd1,
        ST_MWAIT = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [WARM_W-1:0]   warm_cnt, warm_n;
    logic [WAIT_W-1:0]   wait_cnt, wait_n, wait_inc;
    logic                err_set;
    logic                lwstall, branchstall, hz, mem_miss, timeout;
    logic [1:0]          fwd_ae, fwd_be;
    logic                fwd_ad, fwd_bd;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    assign lwstall     = MemtoRegE & (reg_match(RsD, RtE) | reg_match(RtD, RtE));
    assign branchstall = BranchD &
                         ((RegWriteE & (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD))) |
                          (MemtoRegM & (reg_match(WriteRegM, RsD) | reg_match(WriteRegM, RtD))));
    assign hz          = lwstall | branchstall;

    assign fwd_ae = (RegWriteM & reg_match(RsE, WriteRegM)) ? 2'b10 :
                    (RegWriteW & reg_match(RsE, WriteRegW)) ? 2'b01 : 2'b00;
    assign fwd_be = (RegWriteM & reg_match(RtE, WriteRegM)) ? 2'b10 :
                    (RegWriteW & reg_match(RtE, WriteRegW)) ? 2'b01 : 2'b00;
    assign fwd_ad = RegWriteM & reg_match(RsD, WriteRegM);
    assign fwd_bd = RegWriteM & reg_match(RtD, WriteRegM);

    // wait_cnt counts completed wait cycles; the RUN cycle that detects the miss is the first one.
    assign mem_miss = MemAccessM & ~dmem_ready;
    assign wait_inc = wait_cnt + WAIT_W'(1);
    assign timeout  = (wait_inc == WAIT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_WARM;
            warm_cnt  <= WARM_W'(WARMUP);
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_n;
            warm_cnt <= warm_n;
            wait_cnt <= wait_n;
            if (err_set) begin
                mem_err <= 1'b1;
            end
            if (StallF && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and stall/flush decode.
    always_comb begin
        state_n = state;
        warm_n  = warm_cnt;
        wait_n  = wait_cnt;
        err_set = 1'b0;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushW  = 1'b0;
        case (state)
            ST_WARM: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (warm_cnt <= WARM_W'(1)) begin
                    state_n = ST_RUN;
                end else begin
                    warm_n = warm_cnt - WARM_W'(1);
                end
            end
            ST_RUN: begin
                if (mem_miss) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                    if (timeout) begin
                        err_set = 1'b1;
                        wait_n  = '0;
                    end else begin
                        state_n = ST_MWAIT;
                        wait_n  = wait_inc;
                    end
                end else begin
                    StallF = hz;
                    StallD = hz;
                    FlushE = hz;
                    FlushD = (PCSrcD | JumpD) & ~hz;
                end
            end
            ST_MWAIT: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
                if (dmem_ready) begin
                    state_n = ST_RUN;
                    wait_n  = '0;
                end else if (timeout) begin
                    err_set = 1'b1;
                    state_n = ST_RUN;
                    wait_n  = '0;
                end else begin
                    wait_n = wait_inc;
                end
            end
            default: begin
                state_n = ST_WARM;
            end
        endcase
    end

    // Forwarding is suppressed while the pipeline is still being flushed after reset.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        if (state != ST_WARM) begin
            ForwardAE = fwd_ae;
            ForwardBE = fwd_be;
            ForwardAD = fwd_ad;
            ForwardBD = fwd_bd;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized stimulus
// compared against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int unsigned WARMUP      = 3;
    localparam int unsigned MEM_TIMEOUT = 15;
    localparam int unsigned CNT_W       = 16;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       sf, sd, se, sm, fd, fe, fw;
        logic [1:0] fae, fbe;
        logic       fad, fbd;
    } out_t;

    localparam out_t RESET_OUT = 13'b0000110_00_00_0_0;
    localparam out_t ZERO_OUT  = 13'b0;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic BranchD, PCSrcD, JumpD, MemAccessM, dmem_ready;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic ForwardAD, ForwardBD, mem_err;
    logic [CNT_W-1:0] stall_cnt;
    out_t act;

    int checks   = 0;
    int failures = 0;

    int m_warm, m_waited, m_cnt;
    bit m_waiting, m_err;

    hazard_ctrl #(.WARMUP(WARMUP), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
        .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    assign act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                  ForwardAE, ForwardBE, ForwardAD, ForwardBD};

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_warm    = int'(WARMUP);
        m_waiting = 1'b0;
        m_waited  = 0;
        m_err     = 1'b0;
        m_cnt     = 0;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r);
        if (RegWriteM && r != 5'd0 && r == WriteRegM) return 2'b10;
        if (RegWriteW && r != 5'd0 && r == WriteRegW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic uses(input logic [4:0] w);
        return (w != 5'd0) && (w == RsD || w == RtD);
    endfunction

    function automatic out_t model_out();
        out_t o;
        logic lw, br, h;
        o = '0;
        if (m_warm > 0) begin
            o.fd = 1'b1;
            o.fe = 1'b1;
            return o;
        end
        o.fae = fwd_e(RsE);
        o.fbe = fwd_e(RtE);
        o.fad = RegWriteM && RsD != 5'd0 && RsD == WriteRegM;
        o.fbd = RegWriteM && RtD != 5'd0 && RtD == WriteRegM;
        lw = MemtoRegE && RtE != 5'd0 && (RsD == RtE || RtD == RtE);
        br = BranchD && ((RegWriteE && uses(WriteRegE)) || (MemtoRegM && uses(WriteRegM)));
        h  = lw || br;
        if (m_waiting || (MemAccessM && !dmem_ready)) begin
            {o.sf, o.sd, o.se, o.sm, o.fw} = 5'b11111;
        end else begin
            o.sf = h;
            o.sd = h;
            o.fe = h;
            o.fd = (PCSrcD || JumpD) && !h;
        end
        return o;
    endfunction

    function automatic void model_step();
        out_t o = model_out();
        if (o.sf && m_cnt < CNT_MAX) m_cnt++;
        if (m_warm > 0) begin
            m_warm--;
        end else if (m_waiting) begin
            if (dmem_ready) begin
                m_waiting = 1'b0;
                m_waited  = 0;
            end else begin
                m_waited++;
                if (m_waited >= int'(MEM_TIMEOUT)) begin
                    m_err = 1'b1; m_waiting = 1'b0; m_waited = 0;
                end
            end
        end else if (MemAccessM && !dmem_ready) begin
            m_waited = 1;
            if (m_waited >= int'(MEM_TIMEOUT)) begin
                m_err = 1'b1; m_waited = 0;
            end else begin
                m_waiting = 1'b1;
            end
        end
    endfunction

    task automatic idle();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
        {BranchD, PCSrcD, JumpD, MemAccessM} = '0;
        dmem_ready = 1'b1;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (act !== RESET_OUT) begin
            failures++; $display("FAIL reset_out: got %h expected %h", act, RESET_OUT);
        end
        checks++;
        if (mem_err !== 1'b0 || stall_cnt !== '0) begin
            failures++; $display("FAIL reset_regs: mem_err=%b stall_cnt=%0d expected 0/0", mem_err, stall_cnt);
        end
        reset = 1'b1;
    endtask

    task automatic test_warmup();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 3) begin
                RegWriteM = 1'b1; RsE = 5'd7; WriteRegM = 5'd7; RsD = 5'd7;
                MemtoRegE = 1'b1; RtE = 5'd7;
            end
            @(negedge clk);
            checks++;
            if (act !== ((i < 3) ? RESET_OUT : ZERO_OUT)) begin
                failures++; $display("FAIL warmup_cycle%0d: got %h expected %h", i, act,
                                     (i < 3) ? RESET_OUT : ZERO_OUT);
            end
            step();
        end
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== '0) begin
            failures++; $display("FAIL warmup_cnt: got %0d expected 0", stall_cnt);
        end
        step();
    endtask

    task automatic test_load_use();
        idle();
        MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; RtD = 5'd9;
        @(negedge clk);
        checks++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
            failures++; $display("FAIL load_use: got %b expected 1110", {StallF, StallD, FlushE, FlushD});
        end
        step();
        idle();
        MemtoRegE = 1'b1;
        @(negedge clk);
        checks++;
        if (act !== ZERO_OUT || stall_cnt !== CNT_W'(1)) begin
            failures++; $display("FAIL load_use_r0: got %h cnt=%0d expected 0 cnt=1", act, stall_cnt);
        end
        step();
    endtask

    task automatic test_forward();
        idle();
        RsE = 5'd7; WriteRegM = 5'd7; RegWriteM = 1'b1; WriteRegW = 5'd7; RegWriteW = 1'b1;
        RsD = 5'd7;
        @(negedge clk);
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 6'b10_00_1_0) begin
            failures++; $display("FAIL fwd_m: got %b expected 100010",
                                 {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
        end
        step();
        RegWriteM = 1'b0; RtE = 5'd7;
        @(negedge clk);
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 6'b01_01_0_0) begin
            failures++; $display("FAIL fwd_w: got %b expected 010100",
                                 {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
        end
        step();
    endtask

    task automatic test_branch();
        idle();
        BranchD = 1'b1; RsD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3; PCSrcD = 1'b1;
        @(negedge clk);
        checks++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
            failures++; $display("FAIL branch_stall: got %b expected 1110", {StallF, StallD, FlushE, FlushD});
        end
        step();
        RegWriteE = 1'b0;
        @(negedge clk);
        checks++;
        if ({StallF, FlushE, FlushD} !== 3'b001) begin
            failures++; $display("FAIL branch_flush: got %b expected 001", {StallF, FlushE, FlushD});
        end
        step();
        idle();
        JumpD = 1'b1;
        @(negedge clk);
        checks++;
        if (act !== 13'b0000100_00_00_0_0) begin
            failures++; $display("FAIL jump_flush: got %h expected %h", act, 13'b0000100_00_00_0_0);
        end
        step();
        idle();
        BranchD = 1'b1; RtD = 5'd4; MemtoRegM = 1'b1; WriteRegM = 5'd4; PCSrcD = 1'b1;
        @(negedge clk);
        checks++;
        if ({StallF, FlushD} !== 2'b10) begin
            failures++; $display("FAIL branch_load: got %b expected 10", {StallF, FlushD});
        end
        step();
    endtask

    task automatic test_mem_wait();
        idle();
        MemAccessM = 1'b1; dmem_ready = 1'b0;
        MemtoRegE = 1'b1; RtE = 5'd6; RsD = 5'd6; PCSrcD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dmem_ready = (i == 4);
            @(negedge clk);
            checks++;
            if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 7'b1111100) begin
                failures++; $display("FAIL mem_freeze%0d: got %b expected 1111100", i,
                                     {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE});
            end
            step();
        end
        idle();
        @(negedge clk);
        checks++;
        if (act !== ZERO_OUT || mem_err !== 1'b0 || stall_cnt !== CNT_W'(8)) begin
            failures++; $display("FAIL mem_release: got %h err=%b cnt=%0d expected 0 err=0 cnt=8",
                                 act, mem_err, stall_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [6:0] ma  = 7'b1111110;
        logic [6:0] rdy = 7'b0010111;
        logic [6:0] frz = 7'b1111100;
        for (int i = 0; i < 7; i++) begin
            idle();
            MemAccessM = ma[6-i];
            dmem_ready = rdy[6-i];
            @(negedge clk);
            checks++;
            if (StallM !== frz[6-i]) begin
                failures++; $display("FAIL b2b_cycle%0d: got %b expected %b", i, StallM, frz[6-i]);
            end
            step();
        end
    endtask

    task automatic test_timeout();
        idle();
        MemAccessM = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            checks++;
            if (StallE !== 1'b1 || mem_err !== 1'b0) begin
                failures++; $display("FAIL timeout_wait%0d: StallE=%b mem_err=%b expected 1/0", i, StallE, mem_err);
            end
            step();
        end
        idle();
        @(negedge clk);
        checks++;
        if (mem_err !== 1'b1 || StallE !== 1'b0) begin
            failures++; $display("FAIL timeout_err: mem_err=%b StallE=%b expected 1/0", mem_err, StallE);
        end
        step();
        MemAccessM = 1'b1; dmem_ready = 1'b0;
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (act !== RESET_OUT || mem_err !== 1'b0 || stall_cnt !== '0) begin
            failures++; $display("FAIL reset_mid_wait: got %h err=%b cnt=%0d expected %h 0 0",
                                 act, mem_err, stall_cnt, RESET_OUT);
        end
        idle();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_random();
        out_t exp;
        for (int i = 0; i < 600; i++) begin
            RsD = 5'($urandom_range(0, 3));  RtD = 5'($urandom_range(0, 3));
            RsE = 5'($urandom_range(0, 3));  RtE = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3));
            WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
            MemtoRegM = 1'($urandom_range(0, 1)); BranchD   = 1'($urandom_range(0, 1));
            PCSrcD    = 1'($urandom_range(0, 1)); JumpD     = 1'($urandom_range(0, 3) == 0);
            MemAccessM = 1'($urandom_range(0, 5) == 0);
            dmem_ready = 1'($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp = model_out();
            checks++;
            if (act !== exp) begin
                failures++; $display("FAIL rand_out%0d: got %h expected %h", i, act, exp);
            end
            checks++;
            if (mem_err !== m_err || stall_cnt !== CNT_W'(m_cnt)) begin
                failures++; $display("FAIL rand_regs%0d: err=%b cnt=%0d expected %b %0d",
                                     i, mem_err, stall_cnt, m_err, m_cnt);
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_warmup();
        test_load_use();
        test_forward();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
